// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and div_unit.
//   master (execute stage / bench): drives start_i, flush_i, funct3_i, word_i,
//                                   srcA_i, srcB_i; observes busy_o, done_o, result_o
//   slave  (div_unit):              the mirror image
interface div_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic            word_i;
  logic [XLEN-1:0] srcA_i;
  logic [XLEN-1:0] srcB_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, flush_i, funct3_i, word_i, srcA_i, srcB_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, word_i, srcA_i, srcB_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and
// their W variants. One quotient bit per cycle; divide-by-zero and signed
// overflow complete without iterating.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   bus    - div_if slave modport (start/flush/op/operands in, busy/done/result out)
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic  clock,
  input  logic  reset,
  div_if.slave  bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;

  state_t          state, next_state;
  logic [CNT_W-1:0] count, next_count;
  logic [XLEN-1:0] rem, next_rem, quo, next_quo, dvsr, next_dvsr;
  logic [XLEN-1:0] result, next_result;
  logic            neg_q, next_neg_q, neg_r, next_neg_r;
  logic            sel_rem, next_sel_rem, word_op, next_word_op;
  logic            busy, next_busy, done, next_done;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Operand preparation from the live inputs (only consumed in IDLE).
  logic            is_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_val, special_val, special_res;

  always_comb begin
    is_signed = ~bus.funct3_i[0];
    if (bus.word_i) begin
      a_ext   = is_signed ? sext32(bus.srcA_i[31:0]) : {{(XLEN-32){1'b0}}, bus.srcA_i[31:0]};
      b_ext   = is_signed ? sext32(bus.srcB_i[31:0]) : {{(XLEN-32){1'b0}}, bus.srcB_i[31:0]};
      min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end else begin
      a_ext   = bus.srcA_i;
      b_ext   = bus.srcB_i;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    abs_a    = a_neg ? -a_ext : a_ext;
    abs_b    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == ZERO);
    // Operands are already sign-extended, so the word case compares full width too.
    overflow = is_signed & (a_ext == min_val) & (b_ext == ONES);
    special  = div_zero | overflow;
    if (bus.funct3_i[1]) begin
      special_val = div_zero ? a_ext : ZERO;
    end else begin
      special_val = div_zero ? ONES : a_ext;
    end
    special_res = bus.word_i ? sext32(special_val[31:0]) : special_val;
  end

  // One restoring-division step plus final sign correction and result selection.
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] iter_rem, iter_quo, fin_q, fin_r, fin_val, fin_res;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, dvsr};
    fits     = ~diff[XLEN];
    iter_rem = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    iter_quo = {quo[XLEN-2:0], fits};
    fin_q    = neg_q ? -iter_quo : iter_quo;
    fin_r    = neg_r ? -iter_rem : iter_rem;
    fin_val  = sel_rem ? fin_r : fin_q;
    fin_res  = word_op ? sext32(fin_val[31:0]) : fin_val;
  end

  // Next-state and next-datapath logic; flush overrides everything but reset.
  always_comb begin
    next_state   = state;
    next_count   = count;
    next_rem     = rem;
    next_quo     = quo;
    next_dvsr    = dvsr;
    next_neg_q   = neg_q;
    next_neg_r   = neg_r;
    next_sel_rem = sel_rem;
    next_word_op = word_op;
    next_busy    = busy;
    next_done    = 1'b0;
    next_result  = result;
    if (bus.flush_i) begin
      next_state = IDLE;
      next_busy  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          next_busy = 1'b0;
          if (bus.start_i) begin
            next_sel_rem = bus.funct3_i[1];
            next_word_op = bus.word_i;
            next_neg_q   = a_neg ^ b_neg;
            next_neg_r   = a_neg;
            if (special) begin
              next_state  = DONE;
              next_done   = 1'b1;
              next_result = special_res;
            end else begin
              next_state = CALC;
              next_busy  = 1'b1;
              next_count = bus.word_i ? CNT_WORD : CNT_FULL;
              next_rem   = ZERO;
              // Word dividend sits in the top half so it shifts out in 32 steps.
              next_quo   = bus.word_i ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
              next_dvsr  = abs_b;
            end
          end else begin
            next_state = IDLE;
          end
        end
        CALC: begin
          next_rem   = iter_rem;
          next_quo   = iter_quo;
          next_count = count - CNT_ONE;
          if (count == CNT_ONE) begin
            next_state  = DONE;
            next_busy   = 1'b0;
            next_done   = 1'b1;
            next_result = fin_res;
          end else begin
            next_busy = 1'b1;
          end
        end
        DONE: begin
          next_state = IDLE;
          next_busy  = 1'b0;
        end
        default: begin
          next_state = IDLE;
          next_busy  = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= {CNT_W{1'b0}};
      rem     <= ZERO;
      quo     <= ZERO;
      dvsr    <= ZERO;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
      word_op <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= ZERO;
    end else begin
      count   <= next_count;
      rem     <= next_rem;
      quo     <= next_quo;
      dvsr    <= next_dvsr;
      neg_q   <= next_neg_q;
      neg_r   <= next_neg_r;
      sel_rem <= next_sel_rem;
      word_op <= next_word_op;
      busy    <= next_busy;
      done    <= next_done;
      result  <= next_result;
    end
  end

  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized + directed bench for div_unit against a timeline
// model (start cycle, latency, cancel cycle) and a plain-arithmetic result model.
module tb_div_unit;
  localparam int XLEN = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  div_if #(.XLEN(XLEN)) bus();
  div_unit #(.XLEN(XLEN)) dut (.clock(clock), .reset(reset), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          op_active = 1'b0;
  int          op_start = 0;
  int          op_lat = 0;
  int          cut = 0;
  int          zero_at = -1;
  logic [63:0] op_res = 64'h0;
  logic [63:0] committed = 64'h0;
  logic        eb, ed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 32'h0) ||
                  (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) ||
           (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, s32;
    logic [63:0] q, r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'h0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'h0;
      end else if (!f[0]) begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      s32 = f[1] ? r32 : q32;
      return {{32{s32[31]}}, s32};
    end
    if (b == 64'h0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
    end else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a; r = 64'h0;
    end else if (!f[0]) begin
      q = 64'($signed(a) / $signed(b));
      r = 64'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom(), 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return {32'hFFFF_FFFF, $urandom()};
      6: return {$urandom(), 32'h0};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Advance one cycle, drive inputs, and record what the divider must do with them.
  task automatic cycle(input logic st, input logic fl, input logic rs, input logic [2:0] f,
                       input logic w, input logic [63:0] a, input logic [63:0] b);
    @(posedge clock);
    #1;
    cyc++;
    reset        = rs;
    bus.start_i  = st;
    bus.flush_i  = fl;
    bus.funct3_i = f;
    bus.word_i   = w;
    bus.srcA_i   = a;
    bus.srcB_i   = b;
    if (rs || fl) begin
      if (op_active && cut > cyc) cut = cyc;
      if (rs) zero_at = cyc + 1;
    end else if (st && (!op_active || cyc > op_start + op_lat || cyc > cut)) begin
      op_active = 1'b1;
      op_start  = cyc;
      op_lat    = is_special(f, w, a, b) ? 1 : (w ? 33 : 65);
      op_res    = ref_result(f, w, a, b);
      cut       = 1 << 30;
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clock) begin
    if (chk_en) begin
      eb = op_active && cyc > op_start && cyc < op_start + op_lat && cyc <= cut;
      ed = op_active && cyc == op_start + op_lat && cut >= cyc;
      if (ed) committed = op_res;
      if (cyc == zero_at) committed = 64'h0;
      chk("busy_o", {63'h0, bus.busy_o}, {63'h0, eb});
      chk("done_o", {63'h0, bus.done_o}, {63'h0, ed});
      chk("result_o", bus.result_o, committed);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] exp);
    cycle(1'b1, 1'b0, 1'b0, f, w, a, b);
    for (int i = 1; i <= lat; i++) begin
      cycle(1'b0, 1'b0, 1'b0, f, w, rnd(), rnd());
      if (i == 1) chk({name, " busy first"}, {63'h0, bus.busy_o}, {63'h0, (lat > 1)});
      if (i == lat) begin
        chk({name, " done"}, {63'h0, bus.done_o}, 64'h1);
        chk({name, " result"}, bus.result_o, exp);
      end
    end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = 3'b100;
    bus.word_i = 1'b0; bus.srcA_i = 64'h0; bus.srcB_i = 64'h0;

    // Model pins against hand-computed values.
    chk("model divu", ref_result(3'b101, 1'b0, 64'd100, 64'd7), 64'd14);
    chk("model rem", ref_result(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model divw", ref_result(3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF),
        64'hFFFF_FFFF_8000_0000);

    cycle(1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 64'h0, 64'h0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 64'h0, 64'h0);
    chk("reset busy", {63'h0, bus.busy_o}, 64'h0);
    chk("reset done", {63'h0, bus.done_o}, 64'h0);
    chk("reset result", bus.result_o, 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 64'h0, 64'h0);

    run_op("divu", 3'b101, 1'b0, 64'd100, 64'd7, 65, 64'd14);
    run_op("remu", 3'b111, 1'b0, 64'd100, 64'd7, 65, 64'd2);
    run_op("rem", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div by0", 3'b100, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu by0", 3'b111, 1'b0, 64'd5, 64'd0, 1, 64'd5);
    run_op("div ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
           64'h8000_0000_0000_0000);
    run_op("rem ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0);
    run_op("divw ovf", 3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
           64'hFFFF_FFFF_8000_0000);
    run_op("divuw", 3'b101, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 33, 64'h0000_0000_7FFF_FFFF);

    // Flush at cycle 10 of a DIVU, restart in cycle 11, stray start while busy.
    cycle(1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 64'd1000, 64'd3);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 1'b0, 3'b101, 1'b0, rnd(), rnd());
    cycle(1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 64'd1000, 64'd3);
    cycle(1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 64'd1000, 64'd10);
    chk("flush busy", {63'h0, bus.busy_o}, 64'h0);
    chk("flush result kept", bus.result_o, 64'h0000_0000_7FFF_FFFF);
    for (int i = 1; i <= 65; i++) begin
      cycle((i == 4), 1'b0, 1'b0, 3'b100, 1'b0, 64'd5, 64'd0);
      if (i == 65) begin
        chk("restart done", {63'h0, bus.done_o}, 64'h1);
        chk("restart result", bus.result_o, 64'd100);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 64'h0, 64'h0);

    // Reset in the middle of an operation clears the result.
    cycle(1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 64'd77, 64'd5);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, rnd(), rnd());
    cycle(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 64'h0, 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 64'h0, 64'h0);
    chk("midop reset result", bus.result_o, 64'h0);

    // Random traffic: starts, stray starts, rare flushes and resets.
    for (int i = 0; i < 6000; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 999) == 0), 3'(4 + $urandom_range(0, 3)),
            1'($urandom_range(0, 1)), rnd(), rnd());
    end
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 64'h0, 64'h0);

    @(posedge clock);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider that executes all RV64M divide/remainder instructions: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Instantiated inside the execute stage. The execute stage raises its not-ready (stall) output from this block's busy_o/done_o.
- One quotient bit per cycle. Divide-by-zero and signed overflow finish in a single cycle.

Parameters:
XLEN, 64, datapath width. The W-variants always operate on bits [31:0].

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start_i  in  1  request a new divide; sampled only in IDLE
flush_i  in  1  abort the current operation; has priority over everything except reset
funct3_i  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU
word_i  in  1  1 = W-variant (32-bit op, result sign-extended)
srcA_i  in  XLEN  dividend
srcB_i  in  XLEN  divisor
busy_o  out  1  registered; high while in CALC
done_o  out  1  registered; high for exactly one cycle when result_o is valid
result_o  out  XLEN  quotient or remainder; holds its value until the next done_o

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. On reset: state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0: latch the operation and operands.
  - Normal operands: go to CALC, counter = 64 (XLEN), or 32 when word_i=1.
  - Special case: go straight to DONE.
- Operand preparation:
  - Signed ops (funct3_i[0]=0): take absolute values and record the quotient sign (signA xor signB) and remainder sign (signA).
  - word_i=1: operands come from bits [31:0], sign-extended for signed ops, zero-extended for unsigned ops.
- CALC:
  - Each cycle: shift the {remainder, quotient} pair left by 1, trial-subtract the divisor, restore on a negative result, set the quotient LSB, decrement the counter.
  - When the counter reaches 1, apply sign correction and go to DONE.
  - Writing result_o: select the quotient (funct3_i[1]=0) or the remainder (funct3_i[1]=1). For word ops, sign-extend bit 31 to XLEN.
- DONE: done_o=1 for this cycle only, then IDLE. start_i in this cycle is ignored; it is accepted from the next IDLE cycle.
- Latency (start accepted in cycle 0):
  - 64-bit op: busy_o high in cycles 1..64, done_o in cycle 65.
  - Word op: busy_o high in cycles 1..32, done_o in cycle 33.
  - Special case: done_o in cycle 1, busy_o never asserted.
- Special cases, applied after word truncation:
  - Divisor==0: quotient = all ones (before word sign-extension); remainder = dividend.
  - Signed overflow (dividend = most negative value, divisor = -1): quotient = dividend, remainder = 0.
- Back-to-back use: at most one operation per 2 cycles when both are special cases. start_i is ignored while not in IDLE.
- flush_i:
  - Takes effect at the next edge: state=IDLE, busy_o=0, done_o=0.
  - result_o is left unchanged.
  - flush_i together with start_i in IDLE: the start is dropped.
- Reset mid-operation: same effect as flush_i, plus result_o cleared to 0.
- Operand inputs need not be held stable after the start cycle; all computation uses the latched copies.

Test Plan:
- DIVU, A=100, B=7, word_i=0 → busy_o high cycles 1..64; done_o in cycle 65 with result_o=14. REMU with the same operands → 2.
- REM, A=-7, B=2 → result_o=0xFFFF_FFFF_FFFF_FFFF (-1). DIV, A=-7, B=2 → 0xFFFF_FFFF_FFFF_FFFD (-3). Both take 65 cycles.
- DIV, A=5, B=0 → done_o in cycle 1, result_o=0xFFFF_FFFF_FFFF_FFFF. REMU, A=5, B=0 → result_o=5.
- DIV, A=0x8000_0000_0000_0000, B=-1 → cycle 1, result_o=0x8000_0000_0000_0000. REM with the same operands → 0.
- DIVW, A=0x1234_5678_8000_0000, B=0xFFFF_FFFF_FFFF_FFFF → overflow case, result_o=0xFFFF_FFFF_8000_0000. DIVUW, A=0x0000_0000_FFFF_FFFE, B=2 → done_o in cycle 33, result_o=0x0000_0000_7FFF_FFFF.
- Flush at cycle 10 of a DIVU → cycle 11: IDLE, done_o never pulses, result_o unchanged. A new start in cycle 11 completes normally. A second start_i while busy is ignored.
